// File: rtl/pkg_disp.sv
// Shared display-timing types and constants for the HDMI video source:
// porch/sync bundle, default 640x480@60 timing and the colour-bar table.
package pkg_disp;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_fp;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [11:0] v_active;
    logic [11:0] v_fp;
    logic [11:0] v_sync;
    logic [11:0] v_bp;
  } disp_timing_t;

  localparam disp_timing_t T640X480 = '{
    h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
    v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33
  };

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  // Standard bar order, left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/hdmi_timing_gen_if.sv
// Video stream between the timing/pattern source and the TMDS encoders,
// plus the pattern controls the source samples once per frame.
interface hdmi_timing_gen_if;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic        de;
  logic [1:0]  vh;
  logic [11:0] x;
  logic [11:0] y;
  logic        frame_start;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;

  modport master (
    input  pattern_sel, solid_rgb,
    output de, vh, x, y, frame_start, r, g, b
  );

  modport slave (
    output pattern_sel, solid_rgb,
    input  de, vh, x, y, frame_start, r, g, b
  );
endinterface

// File: rtl/disp_pattern.sv
// Combinational test-pattern select; the caller registers the result and
// blanks it outside the active region.
module disp_pattern
  import pkg_disp::*;
(
  input  logic [7:0]  x_lsb,
  input  logic        y_b3,
  input  logic [2:0]  bar_idx,
  input  pattern_e    sel,
  input  logic [23:0] solid_rgb,
  output logic [23:0] rgb
);

  always_comb begin
    // NOTE: default assignment first, so every path drives rgb and no latch is inferred.
    rgb = 24'h000000;
    case (sel)
      PAT_BARS:  rgb = BAR_RGB[bar_idx];
      PAT_RAMP:  rgb = {x_lsb, x_lsb, x_lsb};
      PAT_CHECK: rgb = (x_lsb[3] ^ y_b3) ? 24'hFFFFFF : 24'h000000;
      PAT_SOLID: rgb = solid_rgb;
    endcase
  end

endmodule

// File: rtl/hdmi_timing_gen.sv
// Raster counters, sync decode and per-frame pattern shadow; every output
// is registered from the same counter state so all streams stay aligned.
module hdmi_timing_gen
  import pkg_disp::*;
#(
  parameter int   H_ACTIVE = int'(T640X480.h_active),
  parameter int   H_FP     = int'(T640X480.h_fp),
  parameter int   H_SYNC   = int'(T640X480.h_sync),
  parameter int   H_BP     = int'(T640X480.h_bp),
  parameter int   V_ACTIVE = int'(T640X480.v_active),
  parameter int   V_FP     = int'(T640X480.v_fp),
  parameter int   V_SYNC   = int'(T640X480.v_sync),
  parameter int   V_BP     = int'(T640X480.v_bp),
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input logic               clk,
  input logic               rst,
  hdmi_timing_gen_if.master vid
);

  localparam int          H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

  logic [11:0] hc, vc, bar_cnt;
  logic [2:0]  bar_idx;
  pattern_e    shadow_sel, cur_sel;
  logic [23:0] shadow_rgb, cur_solid, pix_rgb;
  logic        h_wrap, frame_top, active, hs_on, vs_on;

  assign h_wrap    = (hc == H_LAST);
  assign frame_top = (hc == 12'd0) && (vc == 12'd0);
  assign active    = (hc < H_ACT) && (vc < V_ACT);
  assign hs_on     = (hc >= HS_BEG) && (hc < HS_END);
  assign vs_on     = (vc >= VS_BEG) && (vc < VS_END);

  // Pixel (0,0) already belongs to the new frame, so it uses the value being sampled.
  assign cur_sel   = frame_top ? pattern_e'(vid.pattern_sel) : shadow_sel;
  assign cur_solid = frame_top ? vid.solid_rgb : shadow_rgb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc         <= '0;
      vc         <= '0;
      bar_cnt    <= '0;
      bar_idx    <= '0;
      shadow_sel <= PAT_BARS;
      shadow_rgb <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register sees pre-edge counter values.
      if (h_wrap) begin
        hc      <= '0;
        vc      <= (vc == V_LAST) ? 12'd0 : vc + 12'd1;
        bar_cnt <= '0;
        bar_idx <= '0;
      end else begin
        hc <= hc + 12'd1;
        // Bar index advances every H_ACTIVE/8 pixels without a divider.
        if (hc < H_ACT) begin
          if (bar_cnt == BAR_LAST) begin
            bar_cnt <= '0;
            bar_idx <= bar_idx + 3'd1;
          end else begin
            bar_cnt <= bar_cnt + 12'd1;
          end
        end
      end
      if (frame_top) begin
        shadow_sel <= pattern_e'(vid.pattern_sel);
        shadow_rgb <= vid.solid_rgb;
      end
    end
  end

  disp_pattern u_pattern (
    .x_lsb     (hc[7:0]),
    .y_b3      (vc[3]),
    .bar_idx   (bar_idx),
    .sel       (cur_sel),
    .solid_rgb (cur_solid),
    .rgb       (pix_rgb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid.de          <= 1'b0;
      vid.vh          <= {~VS_POL, ~HS_POL};
      vid.x           <= '0;
      vid.y           <= '0;
      vid.frame_start <= 1'b0;
      vid.r           <= '0;
      vid.g           <= '0;
      vid.b           <= '0;
    end else begin
      vid.de                  <= active;
      vid.vh                  <= {vs_on ? VS_POL : ~VS_POL, hs_on ? HS_POL : ~HS_POL};
      vid.x                   <= active ? hc : 12'd0;
      vid.y                   <= active ? vc : 12'd0;
      vid.frame_start         <= frame_top;
      {vid.r, vid.g, vid.b}   <= active ? pix_rgb : 24'h000000;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Scoreboard bench: stimulus queues expected (cycle, field, value) entries for a
// default 640x480 instance and a small-raster instance; a monitor compares each cycle.
module tb_hdmi_timing_gen;
  import pkg_disp::*;

  localparam int F_DE = 0, F_VH = 1, F_X = 2, F_Y = 3, F_FS = 4, F_RGB = 5;

  typedef struct {
    int          dut;
    int          cyc;
    int          fld;
    logic [31:0] val;
  } exp_t;

  exp_t  sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cur   = -1;
  string fname [6] = '{"de", "vh", "x", "y", "frame_start", "rgb"};

  // Bar colours written out independently of the package table.
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic clk = 1'b0;
  logic rst;

  hdmi_timing_gen_if vid_a ();
  hdmi_timing_gen_if vid_b ();

  hdmi_timing_gen dut_a (.clk(clk), .rst(rst), .vid(vid_a));

  // Small raster: 22 clocks per line, 16 lines per frame, 352 clocks per frame.
  hdmi_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_b (.clk(clk), .rst(rst), .vid(vid_b));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int dut, input int cyc, input int fld, input logic [31:0] val);
    exp_t e;
    e.dut = dut;
    e.cyc = cyc;
    e.fld = fld;
    e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int dut, input int fld);
    logic        de, fs;
    logic [1:0]  vh;
    logic [11:0] x, y;
    logic [23:0] rgb;
    if (dut == 0) begin
      de = vid_a.de; vh = vid_a.vh; x = vid_a.x; y = vid_a.y;
      fs = vid_a.frame_start; rgb = {vid_a.r, vid_a.g, vid_a.b};
    end else begin
      de = vid_b.de; vh = vid_b.vh; x = vid_b.x; y = vid_b.y;
      fs = vid_b.frame_start; rgb = {vid_b.r, vid_b.g, vid_b.b};
    end
    case (fld)
      F_DE:    return 32'(de);
      F_VH:    return 32'(vh);
      F_X:     return 32'(x);
      F_Y:     return 32'(y);
      F_FS:    return 32'(fs);
      default: return 32'(rgb);
    endcase
  endfunction

  // Compare and retire every queued entry due at cycle c (-1 = while in reset).
  task automatic score(input int c);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == c) begin
        check($sformatf("%s.%s@t%0d", (sb[i].dut == 0) ? "A" : "B", fname[sb[i].fld], c),
              observe(sb[i].dut, sb[i].fld), sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  // Monitor: t counts output cycles since the last reset release.
  initial begin
    int t = 0;
    @(negedge clk);
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (rst) begin
        score(-1);
        t = 0;
      end else begin
        score(t);
        t++;
      end
    end
  end

  task automatic push_reset_vals();
    for (int d = 0; d < 2; d++) begin
      push(d, -1, F_DE, 0);  push(d, -1, F_VH, 3);  push(d, -1, F_X, 0);
      push(d, -1, F_Y, 0);   push(d, -1, F_FS, 0);  push(d, -1, F_RGB, 0);
    end
  endtask

  task automatic push_first_pixel();
    for (int d = 0; d < 2; d++) begin
      push(d, 0, F_DE, 1);  push(d, 0, F_X, 0);  push(d, 0, F_Y, 0);
      push(d, 0, F_FS, 1);  push(d, 0, F_VH, 3); push(d, 0, F_RGB, 32'hFFFFFF);
      push(d, 1, F_X, 1);   push(d, 1, F_FS, 0);
    end
  endtask

  task automatic wait_t(input int k);
    while (cur < k) begin
      @(negedge clk);
      cur++;
    end
  endtask

  initial begin
    rst = 1'b1;
    vid_a.pattern_sel = 2'd0;  vid_a.solid_rgb = 24'h0;
    vid_b.pattern_sel = 2'd0;  vid_b.solid_rgb = 24'h0;

    push_reset_vals();
    push_first_pixel();

    // Default 640x480 instance: bars, de width, hsync window, line period.
    push(0, 79, F_RGB, 32'hFFFFFF);   push(0, 80, F_RGB, 32'hFFFF00);
    push(0, 160, F_RGB, 32'h00FFFF);  push(0, 240, F_RGB, 32'h00FF00);
    push(0, 320, F_RGB, 32'hFF00FF);  push(0, 400, F_RGB, 32'hFF0000);
    push(0, 480, F_RGB, 32'h0000FF);  push(0, 639, F_RGB, 32'h000000);
    push(0, 639, F_DE, 1);  push(0, 639, F_X, 639);
    push(0, 640, F_DE, 0);  push(0, 640, F_X, 0);  push(0, 640, F_RGB, 0);
    push(0, 655, F_VH, 3);  push(0, 656, F_VH, 2);
    push(0, 751, F_VH, 2);  push(0, 752, F_VH, 3);
    push(0, 799, F_DE, 0);  push(0, 799, F_Y, 0);
    push(0, 800, F_DE, 1);  push(0, 800, F_X, 0);  push(0, 800, F_Y, 1);
    push(0, 800, F_FS, 0);  push(0, 800, F_RGB, 32'hFFFFFF);
    push(0, 1439, F_DE, 1); push(0, 1440, F_DE, 0);

    // Small instance: bars two pixels wide, syncs, line/frame wraps.
    for (int x = 0; x < 16; x++) push(1, x, F_RGB, 32'(bars[x / 2]));
    push(1, 15, F_DE, 1);  push(1, 16, F_DE, 0);  push(1, 16, F_RGB, 0);
    push(1, 17, F_VH, 3);  push(1, 18, F_VH, 2);  push(1, 19, F_VH, 2);  push(1, 20, F_VH, 3);
    push(1, 22, F_X, 0);   push(1, 22, F_Y, 1);   push(1, 22, F_DE, 1);
    push(1, 213, F_Y, 9);  push(1, 213, F_X, 15); push(1, 220, F_DE, 0); push(1, 220, F_Y, 0);
    push(1, 263, F_VH, 3); push(1, 264, F_VH, 1); push(1, 282, F_VH, 0);
    push(1, 307, F_VH, 1); push(1, 308, F_VH, 3);
    for (int t = 0; t < 352; t++) push(1, t, F_DE, 32'(((t % 22) < 16) && ((t / 22) < 10)));
    for (int t = 1; t < 705; t++) push(1, t, F_FS, 32'((t == 352) || (t == 704)));

    // Pattern changes on the small instance, taking effect only at frame starts.
    push(1, 466, F_RGB, 32'h00FFFF);  push(1, 553, F_RGB, 32'hFFFF00);
    push(1, 704, F_RGB, 32'h000000);  push(1, 709, F_RGB, 32'h050505);
    push(1, 719, F_RGB, 32'h0F0F0F);  push(1, 731, F_RGB, 32'h050505);
    push(1, 904, F_RGB, 32'h020202);
    push(1, 1063, F_RGB, 32'h000000); push(1, 1064, F_RGB, 32'hFFFFFF);
    push(1, 1232, F_RGB, 32'hFFFFFF); push(1, 1240, F_RGB, 32'h000000);
    push(1, 1408, F_RGB, 32'h123456); push(1, 1423, F_RGB, 32'h123456);
    push(1, 1424, F_RGB, 32'h000000); push(1, 1424, F_DE, 0);
    push(1, 1481, F_RGB, 32'h123456); push(1, 1606, F_RGB, 32'h123456);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cur = -1;

    wait_t(452);   vid_b.pattern_sel = 2'd1;
    wait_t(760);   vid_b.pattern_sel = 2'd2;
    wait_t(1300);  vid_b.pattern_sel = 2'd3;  vid_b.solid_rgb = 24'h123456;
    wait_t(1500);  vid_b.solid_rgb = 24'hABCDEF;
    wait_t(1700);  vid_b.pattern_sel = 2'd0;

    // Mid-line asynchronous reset, then restart from (0,0).
    wait_t(1808);
    push_reset_vals();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    push_first_pixel();
    push(1, 2, F_RGB, 32'hFFFF00);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < sb.size(); i++) begin
      n_vec++;
      n_err++;
      $display("FAIL missed %s.%s@t%0d: no sample taken, expected %0h",
               (sb[i].dut == 0) ? "A" : "B", fname[sb[i].fld], sb[i].cyc, sb[i].val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
